hm01b0_capture_ctrl: RTL and testbench

Frame-capture sequencer between the HM01B0 camera interface and the JPEG core. It waits for a clean frame boundary, then writes active pixels into a two-bank (ping-pong) stripe buffer of STRIPE_ROWS rows each. It hands completed stripes to the downstream MCU reader over a valid/ack handshake, and reports frame completion and errors.

---
 rtl/hm01b0_capture_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_hm01b0_capture_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hm01b0_capture_ctrl.sv
// HM01B0 frame-capture sequencer: fills a ping-pong stripe buffer from the camera and hands full stripes to the MCU reader.
// Optional HM01B0_CTRL_CONTINUOUS_EN: rearm after every frame instead of returning to IDLE.
module hm01b0_capture_ctrl #(
   parameter int WIDTH       = 320,
   parameter int HEIGHT      = 240,
   parameter int STRIPE_ROWS = 8
) (
   input  logic        mclk,
   input  logic        nreset,
   input  logic [7:0]  cam_pixdata,
   input  logic        cam_hsync,
   input  logic        cam_vsync,
   input  logic        capture_req,
   output logic        busy,
   output logic        wr_en,
   output logic        wr_bank,
   output logic [11:0] wr_addr,
   output logic [7:0]  wr_data,
   output logic        stripe_valid,
   output logic        stripe_bank,
   output logic [4:0]  stripe_index,
   input  logic        stripe_ack,
   output logic        frame_done,
   output logic        overrun,
   output logic        frame_err
);

   localparam int N_STRIPES = HEIGHT / STRIPE_ROWS;
   localparam int COL_W     = $clog2(WIDTH + 1);
   localparam int ROW_W     = (STRIPE_ROWS > 1) ? $clog2(STRIPE_ROWS) : 1;

   localparam logic [COL_W-1:0] COL_MAX  = COL_W'(WIDTH);
   localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(STRIPE_ROWS - 1);
   localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);
   localparam logic [4:0]       IDX_LAST = 5'(N_STRIPES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARM,
      S_WAIT_FRAME,
      S_CAPTURE,
      S_DRAIN
   } state_t;

   state_t state, state_nxt;

   logic [7:0]       pix_q;
   logic             hs_q, vs_q, hs_d, vs_d;
   logic [COL_W-1:0] col;
   logic [ROW_W-1:0] row;
   logic [4:0]       stripe_cnt;
   logic [1:0]       bank_full;
   logic [4:0]       bank_idx [2];
   logic             lock;

   logic accept, start_frame;
   logic in_cap, pix_in, first_pix, ovr_hit;
   logic line_end, stripe_end, last_stripe, early_end, enqueue, consume;

   assign in_cap      = (state == S_CAPTURE);
   assign pix_in      = in_cap && hs_q && (col < COL_MAX);
   assign first_pix   = pix_in && (col == '0) && (row == '0);
   // A new stripe may only start into a bank the reader has released.
   assign ovr_hit     = first_pix && bank_full[wr_bank] && !lock;
   assign line_end    = in_cap && hs_d && !hs_q;
   assign stripe_end  = line_end && (row == ROW_LAST);
   assign last_stripe = stripe_end && (stripe_cnt == IDX_LAST);
   assign early_end   = in_cap && vs_d && !vs_q && !last_stripe;
   assign enqueue     = stripe_end && !lock;
   assign consume     = stripe_valid && stripe_ack;

   assign busy         = (state != S_IDLE);
   assign wr_en        = pix_in && !lock && !ovr_hit;
   assign wr_addr      = 12'(int'(row) * WIDTH + int'(col));
   assign wr_data      = pix_q;
   assign stripe_valid = bank_full[stripe_bank];
   assign stripe_index = bank_idx[stripe_bank];

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      state_nxt   = state;
      accept      = 1'b0;
      start_frame = 1'b0;
      frame_done  = 1'b0;
      case (state)
         S_IDLE: begin
            if (capture_req) begin
               accept    = 1'b1;
               state_nxt = S_ARM;
            end
         end
         S_ARM: begin
            if (!vs_q) state_nxt = S_WAIT_FRAME;
         end
         S_WAIT_FRAME: begin
            if (vs_q && !vs_d) begin
               start_frame = 1'b1;
               state_nxt   = S_CAPTURE;
            end
         end
         S_CAPTURE: begin
            if (last_stripe || early_end) state_nxt = S_DRAIN;
         end
         S_DRAIN: begin
            if (bank_full == 2'b00) begin
               frame_done = 1'b1;
`ifdef HM01B0_CTRL_CONTINUOUS_EN
               state_nxt  = S_WAIT_FRAME;
`else
               state_nxt  = S_IDLE;
`endif
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge mclk) begin
      if (nreset) begin
         state       <= S_IDLE;
         pix_q       <= '0;
         hs_q        <= 1'b0;
         vs_q        <= 1'b0;
         hs_d        <= 1'b0;
         vs_d        <= 1'b0;
         col         <= '0;
         row         <= '0;
         stripe_cnt  <= '0;
         wr_bank     <= 1'b0;
         stripe_bank <= 1'b0;
         bank_full   <= '0;
         // NOTE: the two-entry index array is plain registers, reset so stripe_index reads 0 after reset.
         bank_idx    <= '{default: '0};
         lock        <= 1'b0;
         overrun     <= 1'b0;
         frame_err   <= 1'b0;
      end else begin
         state <= state_nxt;
         pix_q <= cam_pixdata;
         hs_q  <= cam_hsync;
         vs_q  <= cam_vsync;
         hs_d  <= hs_q;
         vs_d  <= vs_q;

         if (accept) begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;
         end
         // Both banks are free here, so read and write pointers realign to bank 0.
         if (start_frame) begin
            col         <= '0;
            row         <= '0;
            stripe_cnt  <= '0;
            wr_bank     <= 1'b0;
            stripe_bank <= 1'b0;
            lock        <= 1'b0;
            overrun     <= 1'b0;
            frame_err   <= 1'b0;
         end
         if (pix_in) col <= col + COL_ONE;
         if (ovr_hit) begin
            overrun <= 1'b1;
            lock    <= 1'b1;
         end
         if (line_end) begin
            col <= '0;
            if (col != COL_MAX) frame_err <= 1'b1;
            row <= stripe_end ? '0 : row + ROW_ONE;
         end
         if (stripe_end) begin
            wr_bank    <= ~wr_bank;
            stripe_cnt <= stripe_cnt + 5'd1;
         end
         if (enqueue) begin
            bank_full[wr_bank] <= 1'b1;
            bank_idx[wr_bank]  <= stripe_cnt;
         end
         if (consume) begin
            bank_full[stripe_bank] <= 1'b0;
            stripe_bank            <= ~stripe_bank;
         end
         if (early_end) frame_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_hm01b0_capture_ctrl.sv
// Self-checking bench for hm01b0_capture_ctrl: camera model, write/stripe scoreboards, scenario table plus hand sequences.
module tb_hm01b0_capture_ctrl;

   localparam int W      = 16;
   localparam int H      = 32;
   localparam int SR     = 4;
   localparam int NS     = H / SR;
   localparam int HB     = 6;
   localparam int VB     = 2;
   localparam int PERIOD = (W + HB) * (H + VB);

   logic        mclk = 1'b0;
   logic        nreset;
   logic [7:0]  cam_pixdata;
   logic        cam_hsync, cam_vsync, capture_req;
   logic        busy, wr_en, wr_bank;
   logic [11:0] wr_addr;
   logic [7:0]  wr_data;
   logic        stripe_valid, stripe_bank;
   logic [4:0]  stripe_index;
   logic        stripe_ack;
   logic        frame_done, overrun, frame_err;

   hm01b0_capture_ctrl #(.WIDTH(W), .HEIGHT(H), .STRIPE_ROWS(SR)) dut (
      .mclk(mclk), .nreset(nreset), .cam_pixdata(cam_pixdata), .cam_hsync(cam_hsync),
      .cam_vsync(cam_vsync), .capture_req(capture_req), .busy(busy), .wr_en(wr_en),
      .wr_bank(wr_bank), .wr_addr(wr_addr), .wr_data(wr_data), .stripe_valid(stripe_valid),
      .stripe_bank(stripe_bank), .stripe_index(stripe_index), .stripe_ack(stripe_ack),
      .frame_done(frame_done), .overrun(overrun), .frame_err(frame_err)
   );

   always #5 mclk = ~mclk;

   typedef struct { logic bank; logic [11:0] addr; logic [7:0] data; int cyc; } px_t;
   typedef struct { logic bank; logic [4:0] idx; } st_t;
   typedef struct {
      int lines; int bad_len; bit hold_ack; int exp_rows; int exp_st; bit exp_err; bit exp_ovr;
   } vec_t;

   px_t exp_px[$];
   st_t exp_st[$];
   int  done_cyc[$];
   px_t mon_px;
   st_t mon_st;
   int  cyc = 0;
   int  done_cnt = 0;
   int  cam_line = -1;
   bit  ack_enable = 1'b1;
   int  n_checks = 0;
   int  n_pass = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge mclk);
      #1;
   endtask

   function automatic logic [7:0] pix(input int p, input int l, input int c);
      return 8'(p * 37 + l * 5 + c * 3);
   endfunction

   always @(posedge mclk) cyc <= cyc + 1;

   // Scoreboard side: every write and every consumed stripe must match the oldest expectation.
   always @(negedge mclk) begin
      if (wr_en === 1'b1) begin
         if (exp_px.size() == 0) check("wr_unexpected", 32'(wr_en), 32'd0);
         else begin
            mon_px = exp_px.pop_front();
            check("wr_bank", 32'(wr_bank), 32'(mon_px.bank));
            check("wr_addr", 32'(wr_addr), 32'(mon_px.addr));
            check("wr_data", 32'(wr_data), 32'(mon_px.data));
            check("wr_latency", 32'(cyc), 32'(mon_px.cyc));
         end
      end
      if (stripe_valid === 1'b1 && stripe_ack === 1'b1) begin
         if (exp_st.size() == 0) check("stripe_unexpected", 32'(stripe_valid), 32'd0);
         else begin
            mon_st = exp_st.pop_front();
            check("stripe_bank", 32'(stripe_bank), 32'(mon_st.bank));
            check("stripe_index", 32'(stripe_index), 32'(mon_st.idx));
         end
      end
      if (frame_done === 1'b1) begin
         done_cnt = done_cnt + 1;
         done_cyc.push_back(cyc);
      end
   end

   // Reader: acknowledge one cycle after each presented stripe when enabled.
   initial begin
      stripe_ack = 1'b0;
      forever begin
         tick();
         stripe_ack = ack_enable && stripe_valid && !stripe_ack;
      end
   end

   task automatic cam_cycle(input logic vs, input logic hs, input logic [7:0] d);
      tick();
      cam_vsync   = vs;
      cam_hsync   = hs;
      cam_pixdata = d;
   endtask

   // One camera frame; rows below exp_rows are expected written, stripes below exp_st_n presented.
   task automatic cam_frame(input int pid, input int lines, input int exp_rows, input int exp_st_n,
                            input int bad_len);
      px_t e;
      st_t s;
      int  len;
      for (int l = 0; l < lines; l++) begin
         cam_line = l;
         for (int h = 0; h < HB; h++) cam_cycle(1'b1, 1'b0, 8'h00);
         len = (l == 5) ? bad_len : W;
         for (int c = 0; c < len; c++) begin
            cam_cycle(1'b1, 1'b1, pix(pid, l, c));
            if (l < exp_rows && c < W) begin
               e.bank = 1'((l / SR) % 2);
               e.addr = 12'((l % SR) * W + c);
               e.data = pix(pid, l, c);
               e.cyc  = cyc + 1;
               exp_px.push_back(e);
            end
         end
         if (l < exp_st_n * SR && (l % SR) == SR - 1) begin
            s.bank = 1'((l / SR) % 2);
            s.idx  = 5'(l / SR);
            exp_st.push_back(s);
         end
      end
      cam_line = -1;
      for (int v = 0; v < VB * (HB + W); v++) cam_cycle(1'b0, 1'b0, 8'h00);
   endtask

   task automatic pulse_req();
      capture_req = 1'b1;
      tick();
      capture_req = 1'b0;
   endtask

   task automatic wait_done(input int target, input string name);
      int n = 0;
      while (done_cnt < target && n < 3000) begin
         tick();
         n++;
      end
      check(name, 32'(done_cnt >= target), 32'd1);
   endtask

`ifndef HM01B0_CTRL_CONTINUOUS_EN
   vec_t vecs[5];

   task automatic run_vec(input vec_t v, input int pid);
      int d0;
      repeat (5) cam_cycle(1'b0, 1'b0, 8'h00);
      ack_enable = !v.hold_ack;
      pulse_req();
      check("req_busy", 32'(busy), 32'd1);
      check("req_sticky_clear", 32'({overrun, frame_err}), 32'd0);
      d0 = done_cnt;
      cam_frame(pid, v.lines, v.exp_rows, v.exp_st, v.bad_len);
      ack_enable = 1'b1;
      wait_done(d0 + 1, "done_timeout");
      repeat (4) tick();
      check("done_once", 32'(done_cnt), 32'(d0 + 1));
      check("end_busy", 32'(busy), 32'd0);
      check("end_overrun", 32'(overrun), 32'(v.exp_ovr));
      check("end_frame_err", 32'(frame_err), 32'(v.exp_err));
      check("px_left", 32'(exp_px.size()), 32'd0);
      check("stripes_left", 32'(exp_st.size()), 32'd0);
   endtask
`endif

   initial begin
      int d0;
      int n;
      nreset      = 1'b1;
      cam_pixdata = 8'h00;
      cam_hsync   = 1'b0;
      cam_vsync   = 1'b0;
      capture_req = 1'b0;
      repeat (3) tick();
      check("rst0_ctl", 32'({busy, wr_en, wr_bank, stripe_valid, stripe_bank, stripe_index,
                             frame_done, overrun, frame_err}), 32'd0);
      check("rst0_wr", 32'({wr_addr, wr_data}), 32'd0);
      nreset = 1'b0;

`ifndef HM01B0_CTRL_CONTINUOUS_EN
      vecs[0] = '{H,  W,     1'b0, H,      NS, 1'b0, 1'b0};
      vecs[1] = '{H,  W,     1'b1, 2 * SR, 2,  1'b0, 1'b1};
      vecs[2] = '{H,  W - 3, 1'b0, H,      NS, 1'b1, 1'b0};
      vecs[3] = '{H,  W + 3, 1'b0, H,      NS, 1'b0, 1'b0};
      vecs[4] = '{13, W,     1'b0, 13,     3,  1'b1, 1'b0};

      for (int i = 0; i < 5; i++) begin
         run_vec(vecs[i], i + 1);
         if (i == 0) begin
            d0 = done_cnt;
            cam_frame(9, H, 0, 0, W);
            check("oneshot_busy", 32'(busy), 32'd0);
            check("oneshot_no_done", 32'(done_cnt), 32'(d0));
         end
      end

      // Request while a frame is already in progress: that frame must be skipped.
      d0 = done_cnt;
      fork
         cam_frame(20, H, 0, 0, W);
         begin
            repeat (100) tick();
            pulse_req();
         end
      join
      check("midreq_busy", 32'(busy), 32'd1);
      cam_frame(21, H, H, NS, W);
      wait_done(d0 + 1, "midreq_done_timeout");
      check("midreq_err", 32'({overrun, frame_err}), 32'd0);
      check("midreq_px_left", 32'(exp_px.size()), 32'd0);

      // Reset in the middle of stripe 5.
      repeat (5) cam_cycle(1'b0, 1'b0, 8'h00);
      pulse_req();
      d0 = done_cnt;
      fork
         cam_frame(30, H, 5 * SR + 2, 5, W);
         begin
            n = 0;
            while (cam_line != 5 * SR + 2 && n < 5000) begin
               tick();
               n++;
            end
            check("rst_reach_timeout", 32'(cam_line == 5 * SR + 2), 32'd1);
            tick();
            nreset = 1'b1;
            tick();
            check("rst_ctl", 32'({busy, wr_en, wr_bank, stripe_valid, stripe_bank, stripe_index,
                                  frame_done, overrun, frame_err}), 32'd0);
            check("rst_wr", 32'({wr_addr, wr_data}), 32'd0);
            nreset = 1'b0;
         end
      join
      repeat (20) tick();
      check("rst_no_done", 32'(done_cnt), 32'(d0));
      check("rst_px_left", 32'(exp_px.size()), 32'd0);
      check("rst_stripes_left", 32'(exp_st.size()), 32'd0);
      run_vec(vecs[0], 31);
`else
      ack_enable = 1'b1;
      repeat (5) cam_cycle(1'b0, 1'b0, 8'h00);
      pulse_req();
      check("cont_busy", 32'(busy), 32'd1);
      for (int f = 0; f < 3; f++) cam_frame(40 + f, H, H, NS, W);
      wait_done(3, "cont_done_timeout");
      check("cont_done_n", 32'(done_cyc.size()), 32'd3);
      if (done_cyc.size() >= 3) begin
         check("cont_period_1", 32'(done_cyc[1] - done_cyc[0]), 32'(PERIOD));
         check("cont_period_2", 32'(done_cyc[2] - done_cyc[1]), 32'(PERIOD));
      end
      check("cont_still_busy", 32'(busy), 32'd1);
      check("cont_flags", 32'({overrun, frame_err}), 32'd0);
      check("cont_px_left", 32'(exp_px.size()), 32'd0);
      check("cont_stripes_left", 32'(exp_st.size()), 32'd0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
